// File: rtl/dmem_xfer_ctrl.sv
// Streaming LOAD/DUMP controller for the data-memory backdoor port.
// LOAD writes a valid/ready stream to consecutive words; DUMP reads them back out.
module dmem_xfer_ctrl #(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_cpu_we,
    output logic          busy,
    output logic          done
);

    localparam int unsigned LW = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          m_valid_d;
    logic [31:0]   m_data_d;
    logic [LW-1:0] clamped_len;
    logic [AW-1:0] start_addr;
    logic          beat;
    logic          fetch;

    // Wrap-around increment that also works for non-power-of-two depths
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + AW'(1);
    endfunction

    // A base beyond DEPTH-1 can only exceed it by less than DEPTH, so one subtraction folds it back
    assign clamped_len = (cmd_len > DEPTH_LEN) ? DEPTH_LEN : cmd_len;
    assign start_addr  = (cmd_base > LAST_ADDR) ? cmd_base - AW'(DEPTH) : cmd_base;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        m_valid_d = m_valid;
        m_data_d  = m_data;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        s_ready   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        beat      = 1'b0;
        fetch     = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = start_addr;
                    rem_d  = clamped_len;
                    if (clamped_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = cmd_write ? LOAD : DUMP;
                    end
                end
            end
            LOAD: begin
                // CPU writes own the memory port; stall the stream for that cycle
                s_ready   = !mem_cpu_we;
                beat      = s_valid && !mem_cpu_we;
                mem_we    = beat;
                mem_addr  = addr_q;
                mem_wdata = s_data;
                if (beat) begin
                    addr_d = next_addr(addr_q);
                    rem_d  = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DUMP: begin
                fetch    = (rem_q != '0) && (!m_valid || m_ready);
                mem_re   = fetch;
                mem_addr = addr_q;
                if (fetch) begin
                    m_data_d  = mem_rdata;
                    m_valid_d = 1'b1;
                    addr_d    = next_addr(addr_q);
                    rem_d     = rem_q - LW'(1);
                end else if (m_valid && m_ready) begin
                    m_valid_d = 1'b0;
                end
                if ((rem_q == '0) && (!m_valid || m_ready)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            m_valid <= m_valid_d;
            m_data  <= m_data_d;
        end
    end

endmodule

// File: tb/tb_dmem_xfer_ctrl.sv
// Randomized bench for dmem_xfer_ctrl: a behavioural memory plus a reference image
// predicts every write, every dumped word and the handshake/done timing.
module tb_dmem_xfer_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          s_valid, s_ready;
    logic [31:0]   s_data;
    logic          m_valid, m_ready;
    logic [31:0]   m_data;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          busy, done;

    logic [31:0] tmem    [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int vectors = 0;
    int errors  = 0;

    dmem_xfer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_cpu_we(cpu_we),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Data memory: CPU port and backdoor port, combinational read
    always @(posedge clk) begin
        if (mem_we) tmem[mem_addr] <= mem_wdata;
        if (cpu_we) tmem[cpu_addr] <= cpu_wdata;
    end
    assign mem_rdata = tmem[mem_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    task automatic cpu_fill(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cpu_we    = 1'b1;
            cpu_addr  = AW'((base + i) % DEPTH);
            cpu_wdata = $urandom;
            ref_mem[(base + i) % DEPTH] = cpu_wdata;
        end
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic check_image(input string tag);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < DEPTH; a++) begin
            if (tmem[a] !== ref_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL image_%s: %0d words differ, first at %0d got %h want %h",
                     tag, bad, first, tmem[first], ref_mem[first]);
        end
    endtask

    // Issue one command and stream a LOAD; cmode: -1 none, -2 random CPU writes, >=0 collide at that cycle
    task automatic do_load(input int base, input int len, input bit rand_valid,
                           input int cmode, input bit seq_data);
        int eff, i, cyc;
        logic [31:0] q[$];
        logic [AW-1:0] exp_addr;
        eff = (len > DEPTH) ? DEPTH : len;
        for (int n = 0; n < eff; n++) q.push_back(seq_data ? 32'hA0 + 32'(n) : $urandom);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = AW'(base); cmd_len = LW'(len);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL load_accept: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        if (eff == 0) begin
            #1;
            vectors++;
            if (done !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0 || s_ready !== 1'b0) begin
                errors++; $display("FAIL load_len0: done=%b we=%b re=%b s_ready=%b want 1 0 0 0",
                                   done, mem_we, mem_re, s_ready);
            end
            @(negedge clk); #1;
            vectors++;
            if (cmd_ready !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL load_len0_idle: cmd_ready=%b done=%b want 1 0", cmd_ready, done);
            end
            return;
        end
        i = 0; cyc = 0;
        while (i < eff && cyc < eff * 4 + 20) begin
            s_valid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data    = q[i];
            cpu_we    = (cmode == -2) ? ($urandom_range(0, 3) == 0) : (cyc == cmode);
            cpu_addr  = (cmode == -2) ? AW'($urandom_range(0, DEPTH - 1)) : AW'((base + i) % DEPTH);
            cpu_wdata = $urandom;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_len   = LW'($urandom_range(0, 7));
            #1;
            exp_addr = AW'((base + i) % DEPTH);
            vectors++;
            if (s_ready !== !cpu_we || mem_we !== (s_valid && !cpu_we) || mem_re !== 1'b0 ||
                busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL load_ctrl cyc %0d: s_ready=%b we=%b re=%b busy=%b done=%b want %b %b 0 1 0",
                         cyc, s_ready, mem_we, mem_re, busy, done, !cpu_we, s_valid && !cpu_we);
            end
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            if (s_valid && !cpu_we) begin
                vectors++;
                if (mem_addr !== exp_addr || mem_wdata !== q[i]) begin
                    errors++;
                    $display("FAIL load_beat %0d: addr=%0d data=%h want %0d %h",
                             i, mem_addr, mem_wdata, exp_addr, q[i]);
                end
                ref_mem[exp_addr] = q[i];
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0; cpu_we = 1'b0; cmd_valid = 1'b0;
        if (i < eff) begin
            vectors++; errors++;
            $display("FAIL load_timeout: %0d of %0d beats accepted", i, eff);
        end
        #1;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || mem_we !== 1'b0 || s_ready !== 1'b0) begin
            errors++; $display("FAIL load_done: done=%b busy=%b we=%b s_ready=%b want 1 1 0 0",
                               done, busy, mem_we, s_ready);
        end
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL load_idle: done=%b cmd_ready=%b busy=%b want 0 1 0", done, cmd_ready, busy);
        end
    endtask

    // rmode: 0 m_ready held high, 1 fixed stall pattern, 2 random
    task automatic do_dump(input int base, input int len, input int rmode);
        int eff, k, nf, cyc;
        bit stall;
        logic [31:0] held;
        bit pat [6];
        pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        eff = (len > DEPTH) ? DEPTH : len;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_base = AW'(base); cmd_len = LW'(len);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL dump_accept: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        m_ready = 1'b1;
        if (eff == 0) begin
            #1;
            vectors++;
            if (done !== 1'b1 || mem_re !== 1'b0 || mem_we !== 1'b0 || m_valid !== 1'b0) begin
                errors++; $display("FAIL dump_len0: done=%b re=%b we=%b m_valid=%b want 1 0 0 0",
                                   done, mem_re, mem_we, m_valid);
            end
            @(negedge clk); #1;
            vectors++;
            if (cmd_ready !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL dump_len0_idle: cmd_ready=%b done=%b want 1 0", cmd_ready, done);
            end
            return;
        end
        k = 0; nf = 0; cyc = 0; stall = 1'b0; held = '0;
        while (k < eff && cyc < eff * 6 + 20) begin
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc < 6) ? pat[cyc] : 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            vectors++;
            if (mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0 ||
                (mem_re === 1'b1 && m_valid === 1'b1 && m_ready === 1'b0)) begin
                errors++;
                $display("FAIL dump_ctrl cyc %0d: we=%b busy=%b done=%b re=%b m_valid=%b m_ready=%b",
                         cyc, mem_we, busy, done, mem_re, m_valid, m_ready);
            end
            if (cyc == 0) begin
                vectors++;
                if (mem_re !== 1'b1 || m_valid !== 1'b0) begin
                    errors++; $display("FAIL dump_first_fetch: re=%b m_valid=%b want 1 0", mem_re, m_valid);
                end
            end
            if (cyc == 1) begin
                vectors++;
                if (m_valid !== 1'b1) begin
                    errors++; $display("FAIL dump_first_valid: m_valid=%b want 1", m_valid);
                end
            end
            if (stall) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++; $display("FAIL dump_stable: m_valid=%b m_data=%h want 1 %h", m_valid, m_data, held);
                end
            end
            if (mem_re === 1'b1) begin
                vectors++;
                if (nf >= eff || mem_addr !== AW'((base + nf) % DEPTH)) begin
                    errors++; $display("FAIL dump_fetch %0d: addr=%0d want %0d", nf, mem_addr, (base + nf) % DEPTH);
                end
                nf++;
            end
            if (m_valid === 1'b1 && m_ready) begin
                vectors++;
                if (m_data !== ref_mem[(base + k) % DEPTH]) begin
                    errors++; $display("FAIL dump_word %0d: got %h want %h", k, m_data, ref_mem[(base + k) % DEPTH]);
                end
                k++;
            end
            stall = (m_valid === 1'b1) && !m_ready;
            held  = m_data;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (k < eff) begin
            vectors++; errors++;
            $display("FAIL dump_timeout: %0d of %0d words delivered", k, eff);
        end
        #1;
        vectors++;
        if (done !== 1'b1 || m_valid !== 1'b0 || mem_re !== 1'b0 || nf != eff) begin
            errors++; $display("FAIL dump_done: done=%b m_valid=%b re=%b fetches=%0d want 1 0 0 %0d",
                               done, m_valid, mem_re, nf, eff);
        end
        if (rmode == 0) begin
            vectors++;
            if (cyc != eff + 1) begin
                errors++; $display("FAIL dump_throughput: done after %0d cycles want %0d", cyc, eff + 1);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL dump_idle: done=%b cmd_ready=%b want 0 1", done, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_base = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0 ||
            m_valid !== 1'b0 || m_data !== 32'h0 || mem_we !== 1'b0 || mem_re !== 1'b0 ||
            mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b busy=%b done=%b s_rdy=%b mv=%b md=%h we=%b re=%b a=%0d wd=%h",
                     cmd_ready, busy, done, s_ready, m_valid, m_data, mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] d [3];
        for (int n = 0; n < 3; n++) d[n] = $urandom;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_base = AW'(200); cmd_len = LW'(5);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            s_valid = 1'b1; s_data = d[n];
            #1;
            vectors++;
            if (mem_we !== 1'b1 || mem_addr !== AW'(200 + n)) begin
                errors++; $display("FAIL abort_beat %0d: we=%b addr=%0d want 1 %0d", n, mem_we, mem_addr, 200 + n);
            end
            ref_mem[200 + n] = d[n];
            @(negedge clk);
        end
        s_data = d[2];
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0 ||
            m_valid !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== '0 ||
            mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: rdy=%b busy=%b done=%b s_rdy=%b mv=%b we=%b re=%b a=%0d wd=%h",
                     cmd_ready, busy, done, s_ready, m_valid, mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done=%b busy=%b want 0 0", done, busy);
        end
        check_image("abort");
    endtask

    initial begin
        test_reset();
        // LOAD basic: 0xA0..0xA3 into 10..13
        do_load(10, 4, 1'b0, -1, 1'b1);
        check_image("load_basic");
        // DUMP across the top of memory
        cpu_fill(DEPTH - 2, 4);
        do_dump(DEPTH - 2, 4, 0);
        // DUMP with output stalls
        cpu_fill(50, 3);
        do_dump(50, 3, 1);
        // CPU write collides with the second beat
        do_load(300, 3, 1'b0, 1, 1'b0);
        check_image("collision");
        // zero length and clamped length
        do_load(7, 0, 1'b0, -1, 1'b0);
        do_dump(7, 0, 0);
        do_load(5, DEPTH + 5, 1'b0, -1, 1'b0);
        check_image("clamp");
        do_dump(5, DEPTH + 5, 0);
        test_reset_mid_load();
        do_load(600, 6, 1'b0, -1, 1'b0);
        do_dump(600, 6, 0);
        // randomized back-to-back commands
        for (int r = 0; r < 10; r++) begin
            int base, len;
            base = $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(1, 24);
            if ($urandom_range(0, 1) == 1) begin
                do_load(base, len, 1'b1, -2, 1'b0);
            end else begin
                cpu_fill(base, len);
                do_dump(base, len, 2);
            end
        end
        @(negedge clk);
        check_image("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
